// File: rtl/execute_hazard_unit.sv
// Forwarding and hazard control for the Execute stage: shadows the E/M/WB instructions to pick
// operand bypass sources, resolves load-use, branch and memory-wait hazards, and counts load-use stalls.
module execute_hazard_unit #(
    parameter int REG_ADDR_WIDTH    = 4,
    parameter int STALL_COUNT_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         d_valid,
    input  logic [REG_ADDR_WIDTH-1:0]    d_src1,
    input  logic [REG_ADDR_WIDTH-1:0]    d_src2,
    input  logic                         d_src1_vec,
    input  logic                         d_src2_vec,
    input  logic                         d_use_src1,
    input  logic                         d_use_src2,
    input  logic [REG_ADDR_WIDTH-1:0]    d_dest,
    input  logic                         d_dest_vec,
    input  logic                         d_writes,
    input  logic                         d_is_load,
    input  logic                         branch_taken,
    input  logic                         mem_wait,
    output logic [1:0]                   data1ScalarForwardSelector,
    output logic [1:0]                   data2ScalarForwardSelector,
    output logic [1:0]                   data1VectorForwardSelector,
    output logic [1:0]                   data2VectorForwardSelector,
    output logic                         stall_f,
    output logic                         stall_d,
    output logic                         flush_d,
    output logic                         flush_e,
    output logic [STALL_COUNT_WIDTH-1:0] stall_count
);

    typedef struct packed {
        logic                      valid;
        logic [REG_ADDR_WIDTH-1:0] dest;
        logic                      dest_vec;
        logic                      writes;
        logic                      is_load;
        logic [REG_ADDR_WIDTH-1:0] src1;
        logic                      src1_vec;
        logic                      use_src1;
        logic [REG_ADDR_WIDTH-1:0] src2;
        logic                      src2_vec;
        logic                      use_src2;
    } stage_t;

    typedef enum logic [1:0] {
        ACT_ADVANCE,
        ACT_BUBBLE,
        ACT_HOLD
    } action_e;

    localparam logic [1:0] SEL_REGFILE = 2'b00;
    localparam logic [1:0] SEL_WB      = 2'b01;
    localparam logic [1:0] SEL_M       = 2'b10;
    localparam logic [STALL_COUNT_WIDTH-1:0] COUNT_ONE = {{(STALL_COUNT_WIDTH-1){1'b0}}, 1'b1};

    stage_t                       e_q, m_q, wb_q;
    stage_t                       d_stage;
    action_e                      action;
    logic                         load_use;
    logic                         count_stall;
    logic [1:0]                   sel1, sel2;
    logic [STALL_COUNT_WIDTH-1:0] count_q;
    logic                         wb_unused;

    // An index only matches a producer writing the same register file.
    function automatic logic produces(stage_t p, logic [REG_ADDR_WIDTH-1:0] idx, logic is_vec);
        return p.valid && p.writes && (p.dest == idx) && (p.dest_vec == is_vec);
    endfunction

    function automatic logic [1:0] bypass_sel(stage_t m, stage_t wb,
                                              logic [REG_ADDR_WIDTH-1:0] idx, logic is_vec);
        if (produces(m, idx, is_vec))
            return SEL_M;
        else if (produces(wb, idx, is_vec))
            return SEL_WB;
        return SEL_REGFILE;
    endfunction

    assign d_stage = '{valid:    d_valid,
                       dest:     d_dest,
                       dest_vec: d_dest_vec,
                       writes:   d_writes,
                       is_load:  d_is_load,
                       src1:     d_src1,
                       src1_vec: d_src1_vec,
                       use_src1: d_use_src1,
                       src2:     d_src2,
                       src2_vec: d_src2_vec,
                       use_src2: d_use_src2};

    always_comb begin
        sel1 = SEL_REGFILE;
        sel2 = SEL_REGFILE;
        if (e_q.valid && e_q.use_src1)
            sel1 = bypass_sel(m_q, wb_q, e_q.src1, e_q.src1_vec);
        if (e_q.valid && e_q.use_src2)
            sel2 = bypass_sel(m_q, wb_q, e_q.src2, e_q.src2_vec);
    end

    assign data1ScalarForwardSelector = e_q.src1_vec ? SEL_REGFILE : sel1;
    assign data1VectorForwardSelector = e_q.src1_vec ? sel1 : SEL_REGFILE;
    assign data2ScalarForwardSelector = e_q.src2_vec ? SEL_REGFILE : sel2;
    assign data2VectorForwardSelector = e_q.src2_vec ? sel2 : SEL_REGFILE;

    // A load in E cannot feed Decode until it reaches WB, so a matching reader must wait one cycle.
    assign load_use = d_valid && e_q.valid && e_q.is_load && e_q.writes &&
                      ((d_use_src1 && (d_src1 == e_q.dest) && (d_src1_vec == e_q.dest_vec)) ||
                       (d_use_src2 && (d_src2 == e_q.dest) && (d_src2_vec == e_q.dest_vec)));

    // Priority: memory wait freezes everything, then branch flush, then load-use stall.
    always_comb begin
        action      = ACT_ADVANCE;
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        flush_d     = 1'b0;
        flush_e     = 1'b0;
        count_stall = 1'b0;
        if (!reset) begin
            if (mem_wait) begin
                action  = ACT_HOLD;
                stall_f = 1'b1;
                stall_d = 1'b1;
            end else if (branch_taken) begin
                action  = ACT_BUBBLE;
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (load_use) begin
                action      = ACT_BUBBLE;
                stall_f     = 1'b1;
                stall_d     = 1'b1;
                flush_e     = 1'b1;
                count_stall = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q  <= '0;
            m_q  <= '0;
            wb_q <= '0;
        end else if (action != ACT_HOLD) begin
            wb_q <= m_q;
            m_q  <= e_q;
            e_q  <= (action == ACT_BUBBLE) ? '0 : d_stage;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count_q <= '0;
        else if (count_stall && (count_q != '1))
            count_q <= count_q + COUNT_ONE;
    end

    assign stall_count = count_q;

    // WB only ever acts as a forwarding producer; its source and load fields are kept for visibility.
    assign wb_unused = ^{wb_q.is_load, wb_q.src1, wb_q.src1_vec, wb_q.use_src1,
                         wb_q.src2, wb_q.src2_vec, wb_q.use_src2};

endmodule

// File: tb/tb_execute_hazard_unit.sv
// Self-checking bench for execute_hazard_unit: directed cycle table, reset/saturation sequences,
// and randomized traffic checked against an in-bench pipeline reference model.
module tb_execute_hazard_unit;

    typedef struct packed {
        logic       valid;
        logic [3:0] dest;
        logic       dest_vec;
        logic       writes;
        logic       is_load;
        logic [3:0] src1;
        logic       src1_vec;
        logic       use1;
        logic [3:0] src2;
        logic       src2_vec;
        logic       use2;
    } instr_t;

    typedef struct {
        instr_t     d;
        logic       br;
        logic       mw;
        logic [1:0] s1s, s2s, s1v, s2v;
        logic [3:0] ctl;
        int         cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        d_valid, d_src1_vec, d_src2_vec, d_use_src1, d_use_src2;
    logic [3:0]  d_src1, d_src2, d_dest;
    logic        d_dest_vec, d_writes, d_is_load, branch_taken, mem_wait;
    logic [1:0]  sel1s, sel2s, sel1v, sel2v;
    logic        stall_f, stall_d, flush_d, flush_e;
    logic [15:0] stall_count;
    logic [1:0]  sat_sel1s, sat_sel2s, sat_sel1v, sat_sel2v;
    logic        sat_stall_f, sat_stall_d, sat_flush_d, sat_flush_e;
    logic [3:0]  sat_stall_count;

    int checks   = 0;
    int failures = 0;

    instr_t model_stage [3];
    int     model_cnt;

    always #5 clk = ~clk;

    execute_hazard_unit #(.REG_ADDR_WIDTH(4), .STALL_COUNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .d_valid(d_valid),
        .d_src1(d_src1), .d_src2(d_src2), .d_src1_vec(d_src1_vec), .d_src2_vec(d_src2_vec),
        .d_use_src1(d_use_src1), .d_use_src2(d_use_src2),
        .d_dest(d_dest), .d_dest_vec(d_dest_vec), .d_writes(d_writes), .d_is_load(d_is_load),
        .branch_taken(branch_taken), .mem_wait(mem_wait),
        .data1ScalarForwardSelector(sel1s), .data2ScalarForwardSelector(sel2s),
        .data1VectorForwardSelector(sel1v), .data2VectorForwardSelector(sel2v),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
        .stall_count(stall_count)
    );

    // Narrow counter instance so saturation is reachable in a few dozen cycles.
    execute_hazard_unit #(.REG_ADDR_WIDTH(4), .STALL_COUNT_WIDTH(4)) u_sat (
        .clk(clk), .reset(reset), .d_valid(d_valid),
        .d_src1(d_src1), .d_src2(d_src2), .d_src1_vec(d_src1_vec), .d_src2_vec(d_src2_vec),
        .d_use_src1(d_use_src1), .d_use_src2(d_use_src2),
        .d_dest(d_dest), .d_dest_vec(d_dest_vec), .d_writes(d_writes), .d_is_load(d_is_load),
        .branch_taken(branch_taken), .mem_wait(mem_wait),
        .data1ScalarForwardSelector(sat_sel1s), .data2ScalarForwardSelector(sat_sel2s),
        .data1VectorForwardSelector(sat_sel1v), .data2VectorForwardSelector(sat_sel2v),
        .stall_f(sat_stall_f), .stall_d(sat_stall_d), .flush_d(sat_flush_d), .flush_e(sat_flush_e),
        .stall_count(sat_stall_count)
    );

    function automatic instr_t mk(logic [3:0] dest, logic dv, logic wr, logic ld,
                                  logic [3:0] s1, logic s1v, logic u1,
                                  logic [3:0] s2, logic s2v, logic u2);
        instr_t r;
        r = '{valid: 1'b1, dest: dest, dest_vec: dv, writes: wr, is_load: ld,
              src1: s1, src1_vec: s1v, use1: u1, src2: s2, src2_vec: s2v, use2: u2};
        return r;
    endfunction

    function automatic vec_t row(instr_t d, logic br, logic mw, logic [1:0] s1s, logic [1:0] s2s,
                                 logic [1:0] s1v, logic [1:0] s2v, logic [3:0] ctl, int cnt);
        vec_t v;
        v.d = d; v.br = br; v.mw = mw;
        v.s1s = s1s; v.s2s = s2s; v.s1v = s1v; v.s2v = s2v;
        v.ctl = ctl; v.cnt = cnt;
        return v;
    endfunction

    task automatic cmp(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(instr_t d, logic br, logic mw);
        d_valid    = d.valid;
        d_dest     = d.dest;
        d_dest_vec = d.dest_vec;
        d_writes   = d.writes;
        d_is_load  = d.is_load;
        d_src1     = d.src1;
        d_src1_vec = d.src1_vec;
        d_use_src1 = d.use1;
        d_src2     = d.src2;
        d_src2_vec = d.src2_vec;
        d_use_src2 = d.use2;
        branch_taken = br;
        mem_wait     = mw;
    endtask

    // ctl packs {stall_f, stall_d, flush_d, flush_e}.
    task automatic checkOutput(string tag, logic [1:0] s1s, logic [1:0] s2s, logic [1:0] s1v,
                               logic [1:0] s2v, logic [3:0] ctl, int cnt);
        cmp({tag, " sel1_scalar"}, 32'(sel1s), 32'(s1s));
        cmp({tag, " sel2_scalar"}, 32'(sel2s), 32'(s2s));
        cmp({tag, " sel1_vector"}, 32'(sel1v), 32'(s1v));
        cmp({tag, " sel2_vector"}, 32'(sel2v), 32'(s2v));
        cmp({tag, " stall_f"}, 32'(stall_f), 32'(ctl[3]));
        cmp({tag, " stall_d"}, 32'(stall_d), 32'(ctl[2]));
        cmp({tag, " flush_d"}, 32'(flush_d), 32'(ctl[1]));
        cmp({tag, " flush_e"}, 32'(flush_e), 32'(ctl[0]));
        cmp({tag, " stall_count"}, 32'(stall_count), cnt);
    endtask

    // Reference model: the youngest older instruction that writes the operand wins.
    function automatic logic [1:0] model_fwd(logic [3:0] src, logic vec, logic u);
        if (!model_stage[0].valid || !u)
            return 2'b00;
        for (int k = 1; k <= 2; k++)
            if (model_stage[k].valid && model_stage[k].writes &&
                model_stage[k].dest == src && model_stage[k].dest_vec == vec)
                return (k == 1) ? 2'b10 : 2'b01;
        return 2'b00;
    endfunction

    function automatic logic model_load_use(instr_t d);
        instr_t e;
        e = model_stage[0];
        if (!(d.valid && e.valid && e.is_load && e.writes))
            return 1'b0;
        return (d.use1 && d.src1 == e.dest && d.src1_vec == e.dest_vec) ||
               (d.use2 && d.src2 == e.dest && d.src2_vec == e.dest_vec);
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t   tbl [24];
        instr_t nop, i1, i2, i3, j1, j3, k1, k2, l1, l2, p1, p2, x;
        logic [1:0] e1s, e2s, e1v, e2v, f1, f2;
        logic [3:0] ectl;
        logic lu;

        nop = '0;
        i1 = mk(4'd3, 0, 1, 0, 4'd1, 0, 1, 4'd2, 0, 1);
        i2 = mk(4'd6, 0, 1, 0, 4'd3, 0, 1, 4'd0, 0, 0);
        i3 = mk(4'd7, 0, 1, 0, 4'd3, 0, 1, 4'd0, 0, 0);
        j1 = mk(4'd5, 0, 1, 0, 4'd1, 0, 1, 4'd0, 0, 0);
        j3 = mk(4'd8, 0, 1, 0, 4'd5, 0, 1, 4'd0, 0, 0);
        k1 = mk(4'd2, 0, 1, 0, 4'd9, 0, 1, 4'd0, 0, 0);
        k2 = mk(4'd10, 1, 1, 0, 4'd2, 1, 1, 4'd2, 0, 1);
        l1 = mk(4'd4, 0, 1, 1, 4'd11, 0, 1, 4'd0, 0, 0);
        l2 = mk(4'd12, 0, 1, 0, 4'd4, 0, 1, 4'd0, 0, 0);
        p1 = mk(4'd4, 0, 1, 1, 4'd0, 0, 0, 4'd0, 0, 0);
        p2 = mk(4'd13, 0, 1, 0, 4'd4, 0, 1, 4'd0, 0, 0);
        x  = mk(4'd4, 0, 1, 1, 4'd4, 0, 1, 4'd0, 0, 0);

        tbl[0]  = row(i1,  0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 0);
        tbl[1]  = row(i2,  0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 0);
        tbl[2]  = row(i3,  0, 0, 2'b10, 2'b00, 2'b00, 2'b00, 4'b0000, 0);
        tbl[3]  = row(nop, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 4'b0000, 0);
        tbl[4]  = row(j1,  0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 0);
        tbl[5]  = row(j1,  0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 0);
        tbl[6]  = row(j3,  0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 0);
        tbl[7]  = row(nop, 0, 0, 2'b10, 2'b00, 2'b00, 2'b00, 4'b0000, 0);
        tbl[8]  = row(k1,  0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 0);
        tbl[9]  = row(k2,  0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 0);
        tbl[10] = row(nop, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 4'b0000, 0);
        tbl[11] = row(nop, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 0);
        tbl[12] = row(l1,  0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 0);
        tbl[13] = row(l2,  0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b1101, 0);
        tbl[14] = row(l2,  0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 1);
        tbl[15] = row(nop, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 4'b0000, 1);
        tbl[16] = row(p1,  0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 1);
        tbl[17] = row(p2,  1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0011, 1);
        tbl[18] = row(nop, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 1);
        tbl[19] = row(p1,  0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 1);
        tbl[20] = row(p2,  1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 4'b1100, 1);
        tbl[21] = row(p2,  1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 4'b1100, 1);
        tbl[22] = row(p2,  1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0011, 1);
        tbl[23] = row(nop, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 1);

        // Reset with hazards requested on the inputs: everything must stay quiet.
        reset = 1'b1;
        applyStimulus(x, 1'b1, 1'b1);
        #12;
        checkOutput("reset_hold", 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 0);
        applyStimulus(nop, 1'b0, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 24; i++) begin
            applyStimulus(tbl[i].d, tbl[i].br, tbl[i].mw);
            #4;
            checkOutput($sformatf("row%0d", i), tbl[i].s1s, tbl[i].s2s, tbl[i].s1v, tbl[i].s2v,
                        tbl[i].ctl, tbl[i].cnt);
            @(posedge clk);
            #1;
        end

        // Reset arriving in the middle of a load-use stall.
        applyStimulus(l1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        applyStimulus(l2, 1'b0, 1'b0);
        #1;
        cmp("midstall stall_f", 32'(stall_f), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("midstall_reset", 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 0);
        applyStimulus(l2, 1'b1, 1'b0);
        #1;
        checkOutput("reset_branch", 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 0);
        cmp("sat reset count", 32'(sat_stall_count), 32'd0);
        applyStimulus(nop, 1'b0, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Self-dependent load repeated: every other cycle is a load-use stall.
        for (int i = 0; i < 41; i++) begin
            applyStimulus(x, 1'b0, 1'b0);
            @(posedge clk);
            #1;
            cmp($sformatf("saturate cycle%0d", i), 32'(sat_stall_count),
                ((i + 1) / 2 > 15) ? 15 : (i + 1) / 2);
        end

        reset = 1'b1;
        applyStimulus(nop, 1'b0, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int k = 0; k < 3; k++) model_stage[k] = '0;
        model_cnt = 0;

        for (int n = 0; n < 400; n++) begin
            instr_t d;
            logic br, mw;
            d.valid    = ($urandom_range(0, 9) != 0);
            d.dest     = 4'($urandom_range(0, 3));
            d.dest_vec = 1'($urandom_range(0, 1));
            d.writes   = ($urandom_range(0, 4) != 0);
            d.is_load  = ($urandom_range(0, 2) == 0);
            d.src1     = 4'($urandom_range(0, 3));
            d.src1_vec = 1'($urandom_range(0, 1));
            d.use1     = 1'($urandom_range(0, 1));
            d.src2     = 4'($urandom_range(0, 3));
            d.src2_vec = 1'($urandom_range(0, 1));
            d.use2     = 1'($urandom_range(0, 1));
            br = ($urandom_range(0, 9) == 0);
            mw = ($urandom_range(0, 7) == 0);
            applyStimulus(d, br, mw);

            f1 = model_fwd(model_stage[0].src1, model_stage[0].src1_vec, model_stage[0].use1);
            f2 = model_fwd(model_stage[0].src2, model_stage[0].src2_vec, model_stage[0].use2);
            e1s = model_stage[0].src1_vec ? 2'b00 : f1;
            e1v = model_stage[0].src1_vec ? f1 : 2'b00;
            e2s = model_stage[0].src2_vec ? 2'b00 : f2;
            e2v = model_stage[0].src2_vec ? f2 : 2'b00;
            lu = model_load_use(d);
            if (mw)      ectl = 4'b1100;
            else if (br) ectl = 4'b0011;
            else if (lu) ectl = 4'b1101;
            else         ectl = 4'b0000;

            #4;
            checkOutput($sformatf("rand%0d", n), e1s, e2s, e1v, e2v, ectl, model_cnt);
            @(posedge clk);
            #1;
            if (!mw) begin
                model_stage[2] = model_stage[1];
                model_stage[1] = model_stage[0];
                model_stage[0] = (br || lu) ? '0 : d;
                if (!br && lu && model_cnt < 65535)
                    model_cnt++;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
